// File: rtl/instr_word_writer.sv
// instr_word_writer
// Takes decoded instruction fields through a valid/ready handshake. Each tuple
// is packed into the 16-bit format {rs2, rs1, rd, op} and written to
// instruction memory over a req/ack interface, one address per word. The
// loader uses this block to fill program memory before the core starts.

module instr_word_writer #(
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 0,
   parameter int LAST_ADDR = 255
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        op,
   input  logic [3:0]        rd,
   input  logic [3:0]        rs1,
   input  logic [3:0]        rs2,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   input  logic              mem_ack,
   output logic              busy,
   output logic              full,
   output logic [ADDR_W:0]   count
);

   localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] LAST_A    = ADDR_W'(LAST_ADDR);
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W:0]   COUNT_ONE = (ADDR_W + 1)'(1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCEPT = 2'd1,
      WRITE  = 2'd2,
      FULL   = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic              mem_req_q, mem_req_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [15:0]       mem_wdata_q, mem_wdata_d;
   logic              full_q, full_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              stop_pending_q, stop_pending_d;

   logic              session_start;
   logic              accept_fire;
   logic              write_done;
   logic              at_last;
   logic [15:0]       packed_word;

   // Event decode: the single-cycle conditions that move the session along.
   always_comb begin
      session_start = 1'b0;
      accept_fire   = 1'b0;
      write_done    = 1'b0;
      at_last       = (mem_addr_q == LAST_A);
      packed_word   = {rs2, rs1, rd, op};
      case (state_q)
         IDLE:    session_start = start;
         FULL:    session_start = start;
         // stop wins over a simultaneous handshake, so the tuple is dropped.
         ACCEPT:  accept_fire   = in_valid & ~stop;
         WRITE:   write_done    = mem_req_q & mem_ack;
         default: session_start = 1'b0;
      endcase
   end

   // Next-state selection for the session FSM.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = ACCEPT;
            end
         end
         ACCEPT: begin
            if (stop) begin
               state_d = IDLE;
            end else if (in_valid) begin
               state_d = WRITE;
            end
         end
         WRITE: begin
            if (write_done) begin
               if (at_last) begin
                  state_d = FULL;
               end else if (stop_pending_q | stop) begin
                  state_d = IDLE;
               end else begin
                  state_d = ACCEPT;
               end
            end
         end
         FULL: begin
            if (start) begin
               state_d = ACCEPT;
            end else if (stop) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath updates: address, packed word, request, count and full flag.
   always_comb begin
      mem_req_d   = mem_req_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      full_d      = full_q;
      count_d     = count_q;

      if (session_start) begin
         mem_addr_d = BASE_A;
         count_d    = '0;
         full_d     = 1'b0;
      end

      if (accept_fire) begin
         mem_wdata_d = packed_word;
         mem_req_d   = 1'b1;
      end

      if (write_done) begin
         mem_req_d = 1'b0;
         count_d   = count_q + COUNT_ONE;
         if (at_last) begin
            full_d = 1'b1;
         end else begin
            mem_addr_d = mem_addr_q + ADDR_ONE;
         end
      end
   end

   // A stop seen while a write is outstanding is remembered until the write ends.
   always_comb begin
      stop_pending_d = stop_pending_q;
      if (session_start) begin
         stop_pending_d = 1'b0;
      end else if (state_q == WRITE) begin
         if (write_done) begin
            stop_pending_d = 1'b0;
         end else if (stop) begin
            stop_pending_d = 1'b1;
         end
      end else begin
         stop_pending_d = 1'b0;
      end
   end

   // State register with synchronous reset; reset overrides every other input.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= IDLE;
         mem_req_q      <= 1'b0;
         mem_addr_q     <= BASE_A;
         mem_wdata_q    <= '0;
         full_q         <= 1'b0;
         count_q        <= '0;
         stop_pending_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         mem_req_q      <= mem_req_d;
         mem_addr_q     <= mem_addr_d;
         mem_wdata_q    <= mem_wdata_d;
         full_q         <= full_d;
         count_q        <= count_d;
         stop_pending_q <= stop_pending_d;
      end
   end

   assign in_ready  = (state_q == ACCEPT);
   assign busy      = (state_q == ACCEPT) | (state_q == WRITE);
   assign mem_req   = mem_req_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign full      = full_q;
   assign count     = count_q;

endmodule

// File: doc/instr_word_writer.md
Name: instr_word_writer

Overview:
- Encoder/writer counterpart to the instruction register's field decode.
- Accepts decoded instruction fields (op, rd, rs1, rs2) through a valid/ready handshake and packs them into the 16-bit instruction format.
- Writes each packed word sequentially into instruction memory over a req/ack write interface.
- Used by the loader/test harness to populate program memory before the core runs.

Parameters:
- ADDR_W, 8: instruction memory address width.
- BASE_ADDR, 0: first address written after start.
- LAST_ADDR, 255: final writable address; writing it sets full.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load session at BASE_ADDR.
- stop  input  1  one-cycle pulse; ends the session and returns to IDLE.
- in_valid  input  1  field tuple valid.
- in_ready  output  1  block accepts a field tuple this cycle.
- op  input  4  opcode field, packed to word[3:0].
- rd  input  4  destination register field, packed to word[7:4].
- rs1  input  4  source 1 field, packed to word[11:8].
- rs2  input  4  source 2 field, packed to word[15:12].
- mem_req  output  1  write request to instruction memory.
- mem_addr  output  ADDR_W  write address.
- mem_wdata  output  16  packed instruction word.
- mem_ack  input  1  memory write complete; sampled only while mem_req=1.
- busy  output  1  high in ACCEPT or WRITE.
- full  output  1  LAST_ADDR has been written.
- count  output  ADDR_W+1  words written this session.

Behaviour:
- Reset, synchronous, active-high. All of the following take effect at the next rising edge, and reset overrides every other input:
  - state=IDLE; in_ready=0; mem_req=0; mem_addr=BASE_ADDR; mem_wdata=0; busy=0; full=0; count=0; stop_pending=0.
- Packing: word = {rs2, rs1, rd, op}. The packed word is registered into mem_wdata on the accepting edge.
- States: IDLE, ACCEPT, WRITE, FULL.
- in_ready is combinational: 1 only in ACCEPT. busy is combinational: 1 in ACCEPT or WRITE.
- IDLE:
  - start=1 -> mem_addr=BASE_ADDR, count=0, full=0, go to ACCEPT.
  - stop is ignored.
- ACCEPT:
  - stop=1 -> go to IDLE (stop has priority over a simultaneous handshake; the tuple is not accepted).
  - Otherwise, in_valid & in_ready -> latch mem_wdata, set mem_req=1, go to WRITE.
  - start is ignored.
- WRITE:
  - mem_req, mem_addr and mem_wdata are held stable until the first edge where mem_ack=1.
  - On ack: mem_req=0 and count+1.
    - If mem_addr==LAST_ADDR: full=1, go to FULL, mem_addr unchanged.
    - Else: mem_addr+1, go to ACCEPT, or go to IDLE if stop_pending.
  - stop during WRITE sets stop_pending. It is cleared on leaving WRITE and when entering ACCEPT from IDLE.
  - start is ignored.
- FULL:
  - in_ready=0; full stays 1.
  - start -> same as from IDLE (restarts at BASE_ADDR, clears full and count).
  - stop -> IDLE; full stays 1 until the next start.
- Latency and throughput:
  - mem_req rises on the edge that accepts the tuple.
  - An ack in the first req cycle gives 2 cycles per word (accept cycle, then req/ack cycle).
  - Arbitrary ack wait states are tolerated.
- mem_ack while mem_req=0 is ignored.
- mem_addr never wraps past LAST_ADDR. Overflow is prevented by the FULL state.
- count saturates naturally at LAST_ADDR-BASE_ADDR+1; its width covers 2^ADDR_W.
- Reset mid-WRITE drops mem_req at that edge. The outstanding write is abandoned, and memory-side cleanup is the memory's responsibility.

Test Plan:
1. Reset, start, one tuple op=3 rd=1 rs1=2 rs2=4, mem_ack tied high -> mem_req high one cycle with mem_addr=0, mem_wdata=0x4213; count=1; in_ready high again 2 cycles after the handshake.
2. Stream 4 tuples, ack delayed 3 cycles each -> mem_addr/mem_wdata stable for all 4 req cycles; addresses 0,1,2,3 in order; in_ready low during each WRITE; count=4.
3. With LAST_ADDR=3, write 4 words and then present a 5th valid -> full=1 after address 3 is acked; state FULL; in_ready stays 0; no 5th mem_req. Then start -> mem_addr=0, count=0, full=0.
4. stop asserted in the middle of a WRITE wait -> write completes on ack, count increments, block returns to IDLE (busy=0) rather than ACCEPT. A following start begins at BASE_ADDR.
5. stop and in_valid in the same ACCEPT cycle -> no mem_req, IDLE next cycle. A spurious mem_ack while idle -> no change to count or mem_addr.
6. Reset asserted while mem_req=1 and ack is withheld -> at the next edge mem_req=0, mem_addr=BASE_ADDR, count=0, full=0, in_ready=0.
